// File: rtl/mult_div_unit_if.sv
// Start/busy/done handshake and HI/LO result bus between the execute-stage
// controller (master) and mult_div_unit (slave).
interface mult_div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [5:0]       funct;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (
    output start, funct, opA, opB,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, funct, opA, opB,
    output busy, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO: shift-add multiply and
// restoring divide, one bit per cycle. Define MDU_DIV_EN to build the divider.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic          clock,
  input  logic          reset,
  mult_div_unit_if.slave bus
);
  localparam int unsigned W2 = 2 * WIDTH;

  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1a;
  localparam logic [5:0] F_DIVU  = 6'h1b;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             neg_lo_q, neg_lo_d;
  logic             pend_q, pend_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dbz_q, dbz_d;
`ifdef MDU_DIV_EN
  logic             is_div_q, is_div_d;
  logic             neg_hi_q, neg_hi_d;
`endif

  // Operand conditioning at acceptance
  logic             sgn_c;
  logic             a_neg_c, b_neg_c;
  logic [WIDTH-1:0] a_abs_c, b_abs_c;
  logic             last_c;
  logic [WIDTH:0]   mul_sum_c;
  logic [W2-1:0]    prod_c;

  assign sgn_c    = (bus.funct == F_MULT) || (bus.funct == F_DIV);
  assign a_neg_c  = sgn_c & bus.opA[WIDTH-1];
  assign b_neg_c  = sgn_c & bus.opB[WIDTH-1];
  assign a_abs_c  = a_neg_c ? (~bus.opA) + WIDTH'(1) : bus.opA;
  assign b_abs_c  = b_neg_c ? (~bus.opB) + WIDTH'(1) : bus.opB;
  assign last_c   = (cnt_q == CNT_W'(WIDTH - 1));
  assign mul_sum_c = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign prod_c   = neg_lo_q ? (~acc_q) + W2'(1) : acc_q;

`ifdef MDU_DIV_EN
  // Restoring step: partial remainder widened by one bit before the trial subtract
  logic [WIDTH:0]   rs_c, diff_c;
  logic [WIDTH-1:0] quo_c, rem_c;
  assign rs_c   = acc_q[W2-1:WIDTH-1];
  assign diff_c = rs_c - {1'b0, b_q};
  assign quo_c  = neg_lo_q ? (~acc_q[WIDTH-1:0]) + WIDTH'(1) : acc_q[WIDTH-1:0];
  assign rem_c  = neg_hi_q ? (~acc_q[W2-1:WIDTH]) + WIDTH'(1) : acc_q[W2-1:WIDTH];
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      neg_lo_q <= 1'b0;
      pend_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbz_q    <= 1'b0;
`ifdef MDU_DIV_EN
      is_div_q <= 1'b0;
      neg_hi_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      neg_lo_q <= neg_lo_d;
      pend_q   <= pend_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dbz_q    <= dbz_d;
`ifdef MDU_DIV_EN
      is_div_q <= is_div_d;
      neg_hi_q <= neg_hi_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    b_d      = b_q;
    neg_lo_d = neg_lo_q;
    pend_d   = pend_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = dbz_q;
`ifdef MDU_DIV_EN
    is_div_d = is_div_q;
    neg_hi_d = neg_hi_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          case (bus.funct)
            F_MULT, F_MULTU: begin
              acc_d    = {WIDTH'(0), b_abs_c};
              b_d      = a_abs_c;
              neg_lo_d = a_neg_c ^ b_neg_c;
              cnt_d    = '0;
              dbz_d    = 1'b0;
              pend_d   = 1'b0;
`ifdef MDU_DIV_EN
              is_div_d = 1'b0;
`endif
              state_d  = S_MUL;
            end
            F_DIV, F_DIVU: begin
              cnt_d    = '0;
              dbz_d    = 1'b0;
`ifdef MDU_DIV_EN
              acc_d    = {WIDTH'(0), a_abs_c};
              b_d      = b_abs_c;
              neg_lo_d = a_neg_c ^ b_neg_c;
              neg_hi_d = a_neg_c;
              is_div_d = 1'b1;
              pend_d   = (bus.opB == '0);
              state_d  = (bus.opB == '0) ? S_FIX : S_DIV;
`else
              // Divider not built: report as unsupported through div_by_zero
              pend_d   = 1'b1;
              state_d  = S_FIX;
`endif
            end
            F_MTHI: begin
              hi_d   = bus.opA;
              done_d = 1'b1;
            end
            F_MTLO: begin
              lo_d   = bus.opA;
              done_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_MUL: begin
        acc_d = {mul_sum_c, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (last_c) state_d = S_FIX;
      end
      S_DIV: begin
`ifdef MDU_DIV_EN
        acc_d = diff_c[WIDTH] ? {rs_c[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                              : {diff_c[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        cnt_d = cnt_q + CNT_W'(1);
        if (last_c) state_d = S_FIX;
`else
        state_d = S_IDLE;
`endif
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (pend_q) begin
          dbz_d = 1'b1;
`ifdef MDU_DIV_EN
        end else if (is_div_q) begin
          hi_d = rem_c;
          lo_d = quo_c;
`endif
        end else begin
          {hi_d, lo_d} = prod_c;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Parametrised multi-cycle multiply/divide unit that adds the MIPS `mult`, `multu`, `div`, `divu`, `mfhi`, `mflo`, `mthi` and `mtlo` operations beside the single-cycle ALU in the execute stage. It owns the architectural HI/LO registers. It runs iterative shift-add multiplication and restoring division, one bit per cycle, under a start/busy/done handshake. The controller stalls the pipeline while `busy` is high and reads HI/LO through `hi`/`lo`.

## Interface
Parameters:
- `WIDTH`, default 32: operand and HI/LO width; must be ≥ 4 and even.
- `CNT_W`, default 6: iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only when `busy`=0.
- `funct`  in  6  operation select, instruction[5:0]: 0x18 mult, 0x19 multu, 0x1a div, 0x1b divu, 0x11 mthi, 0x13 mtlo, 0x10/0x12 (mfhi/mflo) no-op.
- `opA`  in  WIDTH  rs value (dividend / multiplicand / mthi, mtlo source).
- `opB`  in  WIDTH  rt value (divisor / multiplier).
- `busy`  out  1  operation in progress; `start` is ignored while high.
- `done`  out  1  one-cycle pulse when HI/LO have been written.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.
- `div_by_zero`  out  1  last accepted division had `opB`=0; holds until the next accepted `start`.

## Operation
- States: IDLE, MUL, DIV, FIX.
- IDLE + `start` + mult/multu/div/divu:
  - Latch the absolute values of the operands (signed ops) or the raw values (unsigned ops).
  - Record the result signs, clear the counter, clear `div_by_zero`.
  - Go to MUL or DIV.
- IDLE + `start` + mthi/mtlo: write `opA` to HI/LO at that edge; `done` pulses the following cycle; `busy` never rises.
- IDLE + `start` + mfhi/mflo or any other funct: ignored; no state change, no `done`.
- MUL: each cycle, add the multiplicand into a 2·WIDTH accumulator when the current multiplier bit is 1, then shift. After WIDTH iterations, go to FIX.
- DIV: restoring division, one quotient bit per cycle (shift remainder, trial-subtract, restore on negative). After WIDTH iterations, go to FIX.
- DIV with `opB`=0:
  - Detected at acceptance; the state goes directly to FIX.
  - FIX leaves HI/LO unchanged and sets `div_by_zero`=1.
- FIX: apply sign correction and write HI/LO. Return to IDLE.
  - mult/multu: {HI,LO} = full 2·WIDTH product.
  - div/divu: LO = quotient, HI = remainder.
  - Signed division truncates toward zero; the remainder takes the dividend's sign.
  - MIN/−1 wraps: LO = MIN, HI = 0.
- All arithmetic is modulo 2·WIDTH for products and modulo WIDTH for quotient/remainder. Operand inputs are not used after acceptance.

## Timing
- Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0, `div_by_zero`=0; state IDLE, counter 0.
- Let the acceptance edge be E0. Iterations run on edges E1..E_WIDTH. FIX writes HI/LO on edge E_WIDTH+1.
  - `busy` is high from after E0 until E_WIDTH+1.
  - `done` is high for exactly the cycle after E_WIDTH+1.
  - Latency: WIDTH+1 edges, i.e. 33 for WIDTH=32.
- Divide by zero: `busy` is high for the one cycle after E0; FIX occurs at E1; `done` pulses after E1.
- A new `start` is accepted on the same edge that `done` is visible (back-to-back operation). HI/LO read during that cycle already show the new result.
- `reset` mid-operation: at the next edge, abort to IDLE and apply all reset values; no `done`.
- `start` while busy: dropped silently; not queued.

## Configuration
- `MDU_DIV_EN` defined: DIV state and restoring divider are compiled in, as described above.
- `MDU_DIV_EN` undefined:
  - DIV logic is removed.
  - div/divu are accepted and go straight to FIX.
  - HI/LO are unchanged; `div_by_zero` is set to 1 regardless of `opB` (it acts as an "unsupported" flag).
  - `done` pulses one cycle later, with the same timing as divide by zero.

## Test plan
- WIDTH=32, mult opA=0xFFFFFFFD (−3), opB=7 -> after 33 edges `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB; `done` high for exactly one cycle; `busy` high for 33 cycles.
- multu opA=opB=0xFFFFFFFF -> `hi`=0xFFFFFFFE, `lo`=0x00000001; then mult on the same operands back-to-back in the `done` cycle -> `hi`=0, `lo`=1.
- div opA=0xFFFFFFF9 (−7), opB=2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. div 0x80000000 / 0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- mthi 0x1234, then divu opA=7, opB=0 -> `div_by_zero`=1, `hi`=0x1234 unchanged, `done` 2 edges after acceptance. Without `MDU_DIV_EN`, divu 7/2 gives the same response.
- Start multu; assert `reset` at edge E10 -> next cycle `busy`=0, `hi`=`lo`=0, and no `done` pulse ever occurs.
- During a busy mult, pulse `start` with divu 9/3 -> ignored; the final result equals the mult alone; mfhi/mflo with `start` in IDLE -> no `busy`, no `done`.
